led_matrix_scanner: RTL and testbench

//  Display-side consumer of the 8x8 game-of-life board. Takes the full board (grid[r][c], 1 = cell

---
 rtl/led_matrix_scanner.sv | 91 +++++++++
 tb/tb_led_matrix_scanner.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-multiplexed 8x8 LED driver with per-frame snapshot and per-row blanking
module led_matrix_scanner #(
    parameter int DWELL_CYCLES = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [7:0][7:0] grid,
    output logic [7:0]      row_sel,
    output logic [7:0]      col_on,
    output logic            frame_start,
    output logic [2:0]      row_idx
);
    localparam int MAXC = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DL = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BL = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    typedef enum logic [1:0] {IDLE, LOAD, BLANK, DRIVE} state_t;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [7:0][7:0] shadow;
    logic [2:0]      nxt;
    assign nxt = row_idx + 3'd1;
    // Scan FSM; outputs are set on entry to each state so they track the state register exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            row_idx     <= '0;
            shadow      <= '0;
            row_sel     <= '0;
            col_on      <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            state       <= IDLE;
            cnt         <= '0;
            row_idx     <= '0;
            row_sel     <= '0;
            col_on      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    state       <= LOAD;
                    frame_start <= 1'b1;
                end
                LOAD: begin
                    shadow  <= grid;
                    row_idx <= '0;
                    cnt     <= '0;
                    if (BLANK_CYCLES > 0) state <= BLANK;
                    else begin
                        state   <= DRIVE;
                        row_sel <= 8'd1;
                        col_on  <= grid[0];
                    end
                end
                BLANK: begin
                    if (cnt == BL) begin
                        cnt     <= '0;
                        state   <= DRIVE;
                        row_sel <= 8'(1) << row_idx;
                        col_on  <= shadow[row_idx];
                    end else cnt <= cnt + 1'b1;
                end
                DRIVE: begin
                    if (cnt == DL) begin
                        cnt     <= '0;
                        row_sel <= '0;
                        col_on  <= '0;
                        if (row_idx == 3'd7) begin
                            state       <= LOAD;
                            frame_start <= 1'b1;
                            row_idx     <= '0;
                        end else begin
                            row_idx <= nxt;
                            if (BLANK_CYCLES > 0) state <= BLANK;
                            else begin
                                state   <= DRIVE;
                                row_sel <= 8'(1) << nxt;
                                col_on  <= shadow[nxt];
                            end
                        end
                    end else cnt <= cnt + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: directed and random checks of two scanner configurations against a frame-position model
module tb_led_matrix_scanner;
    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            en = 1'b0;
    logic [7:0][7:0] grid = '0;
    logic [7:0]      rs0, co0, rs1, co1;
    logic            fs0, fs1;
    logic [2:0]      ri0, ri1;
    int              tests = 0;
    int              fails = 0;
    bit              act = 0;
    int              p0 = 0;
    int              p1 = 0;
    logic [7:0][7:0] s0 = '0;
    logic [7:0][7:0] s1 = '0;

    always #5 clk = ~clk;

    led_matrix_scanner u0 (.clk(clk), .reset(reset), .en(en), .grid(grid),
        .row_sel(rs0), .col_on(co0), .frame_start(fs0), .row_idx(ri0));
    led_matrix_scanner #(.DWELL_CYCLES(1), .BLANK_CYCLES(0)) u1 (.clk(clk), .reset(reset), .en(en),
        .grid(grid), .row_sel(rs1), .col_on(co1), .frame_start(fs1), .row_idx(ri1));

    // Expected {frame_start,row_idx,row_sel,col_on} from position p within a frame of 1 + 8*(b+d) cycles
    function automatic logic [19:0] model(bit a, int p, logic [7:0][7:0] s, int b, int d);
        int q, r, w;
        if (!a) return 20'd0;
        if (p == 0) return {1'b1, 19'd0};
        q = p - 1;
        r = q / (b + d);
        w = q % (b + d);
        if (w < b) return {1'b0, 3'(r), 16'd0};
        return {1'b0, 3'(r), 8'(1 << r), s[r]};
    endfunction

    // Advance one clock and move the model on from the inputs that were present at the edge
    task automatic tick();
        logic r_, e_;
        logic [7:0][7:0] g;
        r_ = reset;
        e_ = en;
        g = grid;
        @(posedge clk);
        if (r_) begin
            act = 0; p0 = 0; p1 = 0; s0 = '0; s1 = '0;
        end else if (!e_) begin
            act = 0; p0 = 0; p1 = 0;
        end else if (!act) begin
            act = 1; p0 = 0; p1 = 0;
        end else begin
            if (p0 == 0) s0 = g;
            if (p1 == 0) s1 = g;
            p0 = (p0 + 1) % 41;
            p1 = (p1 + 1) % 9;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if ({fs0, ri0, rs0, co0, fs1, ri1, rs1, co1} !== 40'd0) begin
                fails++;
                $display("FAIL reset: got %h/%h %h %h, want all zero", {fs0, ri0}, rs0, co0, {rs1, co1});
            end
        end
    endtask

    task automatic test_diag();
        int last = -1;
        reset = 1'b0;
        for (int r = 0; r < 8; r++) grid[r] = 8'h01 << r;
        for (int i = 0; i < 100; i++) begin
            tick();
            tests += 2;
            if ({fs0, ri0, rs0, co0} !== model(act, p0, s0, 1, 4)) begin
                fails++;
                $display("FAIL diag0: got %h want %h", {fs0, ri0, rs0, co0}, model(act, p0, s0, 1, 4));
            end
            if ({fs1, ri1, rs1, co1} !== model(act, p1, s1, 0, 1)) begin
                fails++;
                $display("FAIL diag1: got %h want %h", {fs1, ri1, rs1, co1}, model(act, p1, s1, 0, 1));
            end
            if (rs0 != 0) begin
                tests++;
                if (co0 !== rs0) begin
                    fails++;
                    $display("FAIL diag_col: col_on %h want %h", co0, rs0);
                end
            end
            if (fs0) begin
                if (last >= 0) begin
                    tests++;
                    if (i - last != 41) begin
                        fails++;
                        $display("FAIL frame_len: got %0d want 41", i - last);
                    end
                end
                last = i;
            end
        end
    endtask

    task automatic test_tear();
        int n;
        grid = {8{8'hFF}};
        n = 0;
        do begin tick(); n++; end while (!fs0 && n < 100);
        n = 0;
        do begin tick(); n++; end while (!(fs0 && n > 1) && n < 100);
        n = 0;
        while (!(ri0 == 3 && rs0 != 0) && n < 60) begin tick(); n++; end
        tests++;
        if (n >= 60) begin
            fails++;
            $display("FAIL tear_wait: row 3 never driven, row_idx %0d", ri0);
        end
        grid = '0;
        n = 0;
        while (!fs0 && n < 60) begin
            if (rs0 != 0) begin
                tests++;
                if (co0 !== 8'hFF) begin
                    fails++;
                    $display("FAIL tear_old: row %0d col_on %h want ff", ri0, co0);
                end
            end
            tick();
            n++;
        end
        for (int i = 0; i < 41; i++) begin
            tick();
            tests += 2;
            if (rs0 != 0 && co0 !== 8'h00) begin
                fails++;
                $display("FAIL tear_new: row %0d col_on %h want 00", ri0, co0);
            end
            if ({fs0, ri0, rs0, co0} !== model(act, p0, s0, 1, 4)) begin
                fails++;
                $display("FAIL tear_model: got %h want %h", {fs0, ri0, rs0, co0}, model(act, p0, s0, 1, 4));
            end
        end
    endtask

    task automatic test_disable();
        int n = 0;
        grid = {8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
        while (!(ri0 == 5 && rs0 != 0) && n < 100) begin tick(); n++; end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL dis_wait: row 5 never driven, row_idx %0d", ri0);
        end
        en = 1'b0;
        tick();
        tests++;
        if ({fs0, ri0, rs0, co0} !== 20'd0) begin
            fails++;
            $display("FAIL dis_dark: got %h want 00000", {fs0, ri0, rs0, co0});
        end
        en = 1'b1;
        tick();
        tests++;
        if (fs0 !== 1'b1 || rs0 !== 8'd0) begin
            fails++;
            $display("FAIL dis_load: frame_start %b row_sel %h want 1/00", fs0, rs0);
        end
        tick();
        tick();
        tests++;
        if (rs0 !== 8'h01 || ri0 !== 3'd0 || co0 !== grid[0]) begin
            fails++;
            $display("FAIL dis_row0: row_sel %h row_idx %0d col_on %h want 01/0/%h", rs0, ri0, co0, grid[0]);
        end
    endtask

    task automatic test_fast();
        int n = 0;
        for (int r = 0; r < 8; r++) grid[r] = 8'($urandom);
        do begin tick(); n++; end while (!(fs1 && n > 1) && n < 20);
        tests++;
        if (!fs1) begin
            fails++;
            $display("FAIL fast_wait: frame_start never seen");
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            tests++;
            if (rs1 !== 8'(1 << k) || co1 !== grid[k] || fs1 !== 1'b0) begin
                fails++;
                $display("FAIL fast_row%0d: row_sel %h col_on %h want %h/%h", k, rs1, co1, 8'(1 << k), grid[k]);
            end
        end
        tick();
        tests++;
        if (fs1 !== 1'b1 || rs1 !== 8'd0) begin
            fails++;
            $display("FAIL fast_wrap: frame_start %b row_sel %h want 1/00", fs1, rs1);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        grid = {8{8'hA5}};
        while (!(ri0 == 6 && rs0 != 0) && n < 100) begin tick(); n++; end
        reset = 1'b1;
        tick();
        tests++;
        if ({fs0, ri0, rs0, co0, fs1, ri1, rs1, co1} !== 40'd0) begin
            fails++;
            $display("FAIL rmid_dark: got %h %h want zero", {fs0, ri0, rs0, co0}, {fs1, ri1, rs1, co1});
        end
        reset = 1'b0;
        grid = '0;
        for (int i = 0; i < 45; i++) begin
            tick();
            tests++;
            if (co0 !== 8'h00 || {fs0, ri0, rs0, co0} !== model(act, p0, s0, 1, 4)) begin
                fails++;
                $display("FAIL rmid_frame: got %h want %h", {fs0, ri0, rs0, co0}, model(act, p0, s0, 1, 4));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            en = ($urandom_range(0, 19) != 0);
            reset = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 5) == 0) grid = {$urandom, $urandom};
            tick();
            tests += 2;
            if ({fs0, ri0, rs0, co0} !== model(act, p0, s0, 1, 4)) begin
                fails++;
                $display("FAIL rand0: cycle %0d got %h want %h", i, {fs0, ri0, rs0, co0}, model(act, p0, s0, 1, 4));
            end
            if ({fs1, ri1, rs1, co1} !== model(act, p1, s1, 0, 1)) begin
                fails++;
                $display("FAIL rand1: cycle %0d got %h want %h", i, {fs1, ri1, rs1, co1}, model(act, p1, s1, 0, 1));
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_diag();
        test_tear();
        test_disable();
        test_fast();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
